// File: rtl/riscv_pkg.sv
// Shared pipeline constants for the hazard/forwarding logic of the 5-stage core.
package riscv_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    StageF,
    StageD,
    StageE,
    StageM,
    StageW
  } stage_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side view of the hazard unit: stage register fields in, stall/flush/forward out.
interface hazard_scoreboard_if #(
  parameter int unsigned AW = 5
);
  logic [AW-1:0] Rs1D, Rs2D, RdD;
  logic          LongOpD;
  logic [AW-1:0] Rs1E, Rs2E, RdE;
  logic          RegWriteE, LoadE, LongIssueE, PCSrcE;
  logic [AW-1:0] RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic          LongDone;
  logic [AW-1:0] LongDoneRd;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          SbErr;

  modport master (
    output Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, RegWriteE, LoadE, LongIssueE, PCSrcE,
    output RdM, RegWriteM, RdW, RegWriteW, LongDone, LongDoneRd,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, SbErr
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, RegWriteE, LoadE, LongIssueE, PCSrcE,
    input  RdM, RegWriteM, RdW, RegWriteW, LongDone, LongDoneRd,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, SbErr
  );
endinterface

// File: rtl/forward_unit.sv
// ALU operand bypass select for one E-stage source register; M result beats W result.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int unsigned AW     = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] rd_m_i,
  input  logic          reg_write_m_i,
  input  logic [AW-1:0] rd_w_i,
  input  logic          reg_write_w_i,
  output logic [1:0]    fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (FWD_EN) begin
      if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
        fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and long-op scoreboard unit: busy bits for in-flight multi-cycle
// results plus an outstanding-op counter, feeding combinational stall/flush/forward controls.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned MAX_OUT = 4,
  parameter bit          FWD_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave hz
);

  localparam int unsigned CW     = clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_OUT);

  logic [NREGS-1:1] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sb_err_q, sb_err_d;
  logic             lw_stall, sb_stall, raw_stall, stall, full;

  // An issue this cycle counts as busy already, so a back-to-back consumer stalls.
  function automatic logic hit(input logic [AW-1:0] r, input logic [NREGS-1:1] busy,
                               input logic issue, input logic [AW-1:0] rd_e);
    return (r != '0) && (busy[r] || (issue && (rd_e == r)));
  endfunction

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    if (hz.LongDone && (hz.LongDoneRd != '0)) begin
      if (!busy_q[hz.LongDoneRd]) sb_err_d = 1'b1;
      busy_d[hz.LongDoneRd] = 1'b0;
    end
    // Set after clear so a same-register issue/done leaves the bit busy.
    if (hz.LongIssueE && (hz.RdE != '0)) busy_d[hz.RdE] = 1'b1;
    case ({hz.LongIssueE, hz.LongDone})
      2'b10: begin
        if (cnt_q == CntMax) sb_err_d = 1'b1;
        else                 cnt_d = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q == '0) sb_err_d = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_comb begin
    full      = ({1'b0, cnt_q} + {{CW{1'b0}}, hz.LongIssueE}) >= {1'b0, CntMax};
    lw_stall  = hz.LoadE && (hz.RdE != '0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    sb_stall  = hit(hz.Rs1D, busy_q, hz.LongIssueE, hz.RdE)
             || hit(hz.Rs2D, busy_q, hz.LongIssueE, hz.RdE)
             || (hz.LongOpD && (hit(hz.RdD, busy_q, hz.LongIssueE, hz.RdE) || full));
    // Without bypassing, E and M producers must drain; W writes the RF on the falling edge.
    raw_stall = !FWD_EN
             && ((hz.RegWriteE && (hz.RdE != '0)
                  && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)))
              || (hz.RegWriteM && (hz.RdM != '0)
                  && ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D))));
    stall     = lw_stall || sb_stall || raw_stall;
    hz.StallF = stall && !hz.PCSrcE;
    hz.StallD = stall && !hz.PCSrcE;
    hz.FlushD = hz.PCSrcE;
    hz.FlushE = stall || hz.PCSrcE;
    hz.SbErr  = sb_err_q;
  end

  forward_unit #(
    .AW     (AW),
    .FWD_EN (FWD_EN)
  ) u_fwd_a (
    .rs_i          (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (hz.ForwardAE)
  );

  forward_unit #(
    .AW     (AW),
    .FWD_EN (FWD_EN)
  ) u_fwd_b (
    .rs_i          (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (hz.ForwardBE)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance and a MAX_OUT=2 / no-forwarding instance
// share one stimulus stream, each checked against its own behavioural model.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rdd;
    logic       longopd;
    logic [4:0] rs1e, rs2e, rde;
    logic       regwritee, loade, longissuee, pcsrce;
    logic [4:0] rdm;
    logic       regwritem;
    logic [4:0] rdw;
    logic       regwritew;
    logic       longdone;
    logic [4:0] ldrd;
  } stim_t;

  logic  clk = 1'b0;
  logic  reset_n;
  stim_t s;

  bit busy_m[2][32];
  int cnt_m[2];
  bit err_m[2];
  int max_m[2] = '{4, 2};
  bit fwd_m[2] = '{1'b1, 1'b0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(5)) if0 ();
  hazard_scoreboard_if #(.AW(5)) if1 ();

  assign if0.Rs1D = s.rs1d;             assign if1.Rs1D = s.rs1d;
  assign if0.Rs2D = s.rs2d;             assign if1.Rs2D = s.rs2d;
  assign if0.RdD = s.rdd;               assign if1.RdD = s.rdd;
  assign if0.LongOpD = s.longopd;       assign if1.LongOpD = s.longopd;
  assign if0.Rs1E = s.rs1e;             assign if1.Rs1E = s.rs1e;
  assign if0.Rs2E = s.rs2e;             assign if1.Rs2E = s.rs2e;
  assign if0.RdE = s.rde;               assign if1.RdE = s.rde;
  assign if0.RegWriteE = s.regwritee;   assign if1.RegWriteE = s.regwritee;
  assign if0.LoadE = s.loade;           assign if1.LoadE = s.loade;
  assign if0.LongIssueE = s.longissuee; assign if1.LongIssueE = s.longissuee;
  assign if0.PCSrcE = s.pcsrce;         assign if1.PCSrcE = s.pcsrce;
  assign if0.RdM = s.rdm;               assign if1.RdM = s.rdm;
  assign if0.RegWriteM = s.regwritem;   assign if1.RegWriteM = s.regwritem;
  assign if0.RdW = s.rdw;               assign if1.RdW = s.rdw;
  assign if0.RegWriteW = s.regwritew;   assign if1.RegWriteW = s.regwritew;
  assign if0.LongDone = s.longdone;     assign if1.LongDone = s.longdone;
  assign if0.LongDoneRd = s.ldrd;       assign if1.LongDoneRd = s.ldrd;

  hazard_scoreboard #(
    .NREGS   (32),
    .AW      (5),
    .MAX_OUT (4),
    .FWD_EN  (1'b1)
  ) dut0 (
    .clk   (clk),
    .reset (reset_n),
    .hz    (if0.slave)
  );

  hazard_scoreboard #(
    .NREGS   (32),
    .AW      (5),
    .MAX_OUT (2),
    .FWD_EN  (1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset_n),
    .hz    (if1.slave)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int i, input logic [4:0] r);
    return (r != 0) && (busy_m[i][r] || (s.longissuee && (s.rde == r)));
  endfunction

  function automatic bit uses(input logic [4:0] rd);
    return (rd != 0) && ((rd == s.rs1d) || (rd == s.rs2d));
  endfunction

  function automatic bit exp_stall(input int i);
    bit lw, sb, raw;
    lw  = s.loade && uses(s.rde);
    sb  = hit(i, s.rs1d) || hit(i, s.rs2d)
       || (s.longopd && (hit(i, s.rdd) || (cnt_m[i] + int'(s.longissuee) >= max_m[i])));
    raw = !fwd_m[i] && ((s.regwritee && uses(s.rde)) || (s.regwritem && uses(s.rdm)));
    return lw || sb || raw;
  endfunction

  function automatic logic [1:0] exp_fwd(input int i, input logic [4:0] rs);
    if (!fwd_m[i]) return 2'b00;
    if (s.regwritem && (s.rdm != 0) && (s.rdm == rs)) return 2'b10;
    if (s.regwritew && (s.rdw != 0) && (s.rdw == rs)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) busy_m[i][r] = 1'b0;
      cnt_m[i] = 0;
      err_m[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (s.longdone && (s.ldrd != 0) && !busy_m[i][s.ldrd]) err_m[i] = 1'b1;
      if (s.longissuee && !s.longdone) begin
        if (cnt_m[i] == max_m[i]) err_m[i] = 1'b1;
        else cnt_m[i]++;
      end else if (!s.longissuee && s.longdone) begin
        if (cnt_m[i] == 0) err_m[i] = 1'b1;
        else cnt_m[i]--;
      end
      if (s.longdone && (s.ldrd != 0)) busy_m[i][s.ldrd] = 1'b0;
      if (s.longissuee && (s.rde != 0)) busy_m[i][s.rde] = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      logic       sf, sd, fd, fe, er;
      logic [1:0] oa, ob;
      bit         st;
      if (i == 0) begin
        sf = if0.StallF; sd = if0.StallD; fd = if0.FlushD; fe = if0.FlushE;
        oa = if0.ForwardAE; ob = if0.ForwardBE; er = if0.SbErr;
      end else begin
        sf = if1.StallF; sd = if1.StallD; fd = if1.FlushD; fe = if1.FlushE;
        oa = if1.ForwardAE; ob = if1.ForwardBE; er = if1.SbErr;
      end
      st = exp_stall(i);
      chk($sformatf("%s u%0d StallF", ph, i), {1'b0, sf}, {1'b0, st && !s.pcsrce});
      chk($sformatf("%s u%0d StallD", ph, i), {1'b0, sd}, {1'b0, st && !s.pcsrce});
      chk($sformatf("%s u%0d FlushD", ph, i), {1'b0, fd}, {1'b0, s.pcsrce});
      chk($sformatf("%s u%0d FlushE", ph, i), {1'b0, fe}, {1'b0, st || s.pcsrce});
      chk($sformatf("%s u%0d ForwardAE", ph, i), oa, exp_fwd(i, s.rs1e));
      chk($sformatf("%s u%0d ForwardBE", ph, i), ob, exp_fwd(i, s.rs2e));
      chk($sformatf("%s u%0d SbErr", ph, i), {1'b0, er}, {1'b0, err_m[i]});
    end
  endtask

  // Inputs are applied one time unit after the rising edge; compare at the falling edge.
  task automatic settle(input string ph);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic step(input string ph);
    settle(ph);
    tick();
  endtask

  initial begin
    int busy_list[$];
    reset_n = 1'b0;
    s = '0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    step("idle");

    // Load-use stall, then M forwarding of the loaded value.
    s = '0; s.loade = 1; s.regwritee = 1; s.rde = 5; s.rs1d = 5;
    settle("loaduse");
    chk("loaduse const StallF", {1'b0, if0.StallF}, 2'b01);
    chk("loaduse const FlushE", {1'b0, if0.FlushE}, 2'b01);
    tick();
    s = '0; s.rdm = 5; s.regwritem = 1; s.rs1e = 5;
    settle("loadfwd");
    chk("loadfwd const ForwardAE", if0.ForwardAE, 2'b10);
    tick();

    // Long op on x7 with a dependent instruction held in D through the done cycle.
    s = '0; s.longissuee = 1; s.rde = 7; s.rs2d = 7;
    step("long issue");
    s = '0; s.rs2d = 7;
    step("long wait1");
    step("long wait2");
    s.longdone = 1; s.ldrd = 7;
    settle("long done");
    chk("long done const StallD", {1'b0, if0.StallD}, 2'b01);
    tick();
    s = '0; s.rs2d = 7;
    settle("long release");
    chk("long release const StallD", {1'b0, if0.StallD}, 2'b00);
    tick();

    // Counter full on the MAX_OUT=2 instance, then WAW on a busy destination.
    s = '0; s.longissuee = 1; s.rde = 3;
    step("full iss3");
    s.rde = 4;
    step("full iss4");
    s = '0; s.longopd = 1; s.rdd = 9;
    settle("full");
    chk("full const u1 StallD", {1'b0, if1.StallD}, 2'b01);
    chk("full const u0 StallD", {1'b0, if0.StallD}, 2'b00);
    tick();
    s.longdone = 1; s.ldrd = 3;
    step("full done3");
    s.longdone = 0;
    step("full released");
    s.rdd = 4;
    settle("waw");
    chk("waw const u0 StallD", {1'b0, if0.StallD}, 2'b01);
    tick();
    s = '0; s.longdone = 1; s.ldrd = 4;
    step("waw done4");

    // Taken branch overrides a scoreboard stall.
    s = '0; s.longissuee = 1; s.rde = 8;
    step("br issue");
    s = '0; s.rs1d = 8; s.pcsrce = 1;
    settle("branch");
    chk("branch const StallF", {1'b0, if0.StallF}, 2'b00);
    chk("branch const FlushD", {1'b0, if0.FlushD}, 2'b01);
    chk("branch const FlushE", {1'b0, if0.FlushE}, 2'b01);
    tick();
    s = '0; s.longdone = 1; s.ldrd = 8;
    step("br done");

    // Forward priority, x0 exclusion, and the no-forwarding RAW stall.
    s = '0; s.rdm = 6; s.rdw = 6; s.rs1e = 6; s.regwritem = 1; s.regwritew = 1;
    s.rs2e = 9;
    step("fwd prio");
    s.rdw = 9;
    step("fwd wb");
    s = '0; s.regwritem = 1; s.regwritew = 1; s.regwritee = 1;
    step("fwd x0");
    s = '0; s.regwritee = 1; s.rde = 6; s.rs1d = 6;
    settle("raw");
    chk("raw const u1 StallD", {1'b0, if1.StallD}, 2'b01);
    chk("raw const u0 StallD", {1'b0, if0.StallD}, 2'b00);
    tick();

    // Done for a non-busy register raises the sticky error.
    s = '0; s.longdone = 1; s.ldrd = 10;
    step("err done");
    s = '0;
    settle("err set");
    chk("err const SbErr", {1'b0, if0.SbErr}, 2'b01);
    tick();
    step("err sticky");

    // Asynchronous reset in the middle of a scoreboard stall.
    s = '0; s.longissuee = 1; s.rde = 11;
    step("rst issue");
    s = '0; s.rs1d = 11;
    settle("rst stall");
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst async");
    chk("rst const StallF", {1'b0, if0.StallF}, 2'b00);
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      s = '0;
      s.rs1d = 5'($urandom_range(0, 7));
      s.rs2d = 5'($urandom_range(0, 7));
      s.rdd = 5'($urandom_range(0, 7));
      s.longopd = ($urandom_range(0, 3) == 0);
      s.rs1e = 5'($urandom_range(0, 7));
      s.rs2e = 5'($urandom_range(0, 7));
      s.rde = 5'($urandom_range(0, 7));
      s.regwritee = 1'($urandom);
      s.loade = ($urandom_range(0, 3) == 0);
      s.pcsrce = ($urandom_range(0, 7) == 0);
      s.rdm = 5'($urandom_range(0, 7));
      s.regwritem = 1'($urandom);
      s.rdw = 5'($urandom_range(0, 7));
      s.regwritew = 1'($urandom);
      s.longissuee = (cnt_m[0] < 2) && ($urandom_range(0, 3) == 0) && !busy_m[0][s.rde];
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (busy_m[0][r]) busy_list.push_back(r);
      if ((cnt_m[0] > 0) && ($urandom_range(0, 3) == 0)) begin
        s.longdone = 1;
        s.ldrd = (busy_list.size() > 0)
               ? 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]) : 5'd0;
      end else if ($urandom_range(0, 63) == 0) begin
        s.longdone = 1;
        s.ldrd = 5'($urandom_range(0, 15));
      end
      step($sformatf("rand%0d", c));
      if ((c % 150) == 149) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rand rst");
        @(posedge clk);
        #2 reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard, forwarding and scoreboard unit for the 5-stage pipelined RISC-V core (F/D/E/M/W). It replaces the purely combinational hazard logic.
- Sequential part: tracks destination registers of in-flight long-latency ops (multi-cycle mul/div) in a per-register busy scoreboard, plus an outstanding-op counter.
- Combinational part: produces stall, flush and forward controls.

Parameters:
NREGS, 32, number of architectural registers; x0 is hard-wired zero.
AW, 5, register address width; must equal clog2(NREGS).
MAX_OUT, 4, maximum simultaneously outstanding long ops (1..NREGS-1).
FWD_EN, 1, 1 = M/W forwarding enabled; 0 = resolve RAW by stalling only.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Rs1D, Rs2D  in  AW each  source registers of the instruction in D.
RdD  in  AW  destination of the instruction in D.
LongOpD  in  1  instruction in D is a long-latency op.
Rs1E, Rs2E  in  AW each  source registers of the instruction in E.
RdE  in  AW  destination of the instruction in E.
RegWriteE  in  1  instruction in E writes a register.
LoadE  in  1  instruction in E is a load.
LongIssueE  in  1  long op in E issues to the multi-cycle unit this cycle.
PCSrcE  in  1  taken branch/jump resolved in E.
RdM, RegWriteM  in  AW, 1  destination and write enable of the M stage.
RdW, RegWriteW  in  AW, 1  destination and write enable of the W stage.
LongDone, LongDoneRd  in  1, AW  long op completes; its result is written to the register file this cycle.
StallF, StallD  out  1 each  hold the PC and the F/D register.
FlushD, FlushE  out  1 each  clear the F/D and D/E registers.
ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M result.
SbErr  out  1  sticky protocol error flag.

Behaviour:
- State:
  - busy[NREGS-1:1]
  - cnt, width clog2(MAX_OUT+1)
  - SbErr
  - All cleared asynchronously when reset=0.
  - Every combinational output is 0 when all inputs are 0.
- Scoreboard set:
  - busy[LongRdE] is set at the clock edge when LongIssueE=1 and RdE!=0. cnt increments.
  - LongIssueE with RdE=0 still increments cnt; LongDone with LongDoneRd=0 decrements it.
- Scoreboard clear:
  - busy[LongDoneRd] is cleared at the clock edge when LongDone=1. cnt decrements.
  - The clear takes effect only at the edge, so a dependent instruction stays stalled during the LongDone cycle and proceeds the next cycle.
- Simultaneous events:
  - Issue and done on the same register: set wins.
  - Issue and done together: cnt is unchanged.
- SbErr is set and held until reset on any of:
  - LongDone to a register whose busy bit is clear;
  - cnt decrement at 0;
  - increment at MAX_OUT.
  - cnt saturates rather than wraps.
- hit(r): r!=0 and (busy[r], or LongIssueE with RdE==r).
- Stall conditions:
  - lwStall: LoadE and RdE!=0 and RdE in {Rs1D, Rs2D}.
  - sbStall: hit(Rs1D) or hit(Rs2D); also hit(RdD) when LongOpD=1 (WAW); also LongOpD with cnt + LongIssueE >= MAX_OUT (full).
  - FWD_EN=0 adds rawStall: RegWriteE or RegWriteM with matching nonzero RdE/RdM in {Rs1D, Rs2D}. W needs no stall because the register file writes on the falling edge.
  - stall = lwStall | sbStall | rawStall.
- Control outputs:
  - StallF = StallD = stall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = stall | PCSrcE.
  - A taken branch overrides a stall; the stalled D instruction is wrong-path and is discarded.
- ForwardAE (ForwardBE is identical with Rs2E):
  - 10 if RegWriteM, RdM!=0 and RdM==Rs1E;
  - else 01 if RegWriteW, RdW!=0 and RdW==Rs1E;
  - else 00.
  - M has priority over W.
  - Forced to 00 when FWD_EN=0.
- Latency: outputs are combinational from inputs and registered state. The scoreboard updates one edge after issue/done.
- Reset asserted mid-operation discards all busy bits. The core flushes the multi-cycle unit on the same reset.

Decomposition:
- Package riscv_pkg holds:
  - the forward-select encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the stage naming constants;
  - a clog2 function.
- One natural sub-module, forward_unit: combinational M/W match and priority, instantiated once per operand.
- Scoreboard, counter and stall logic stay in hazard_scoreboard.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle. Next cycle RdM=5, Rs1E=5, RegWriteM=1 -> ForwardAE=10.
- Long op: LongIssueE with RdE=7, then Rs2D=7 held in D -> stall every cycle, including the LongDone(7) cycle. Released the cycle after; cnt returns 0, SbErr=0.
- Full and WAW (MAX_OUT=2): issue to x3 and x4, then LongOpD with RdD=9 -> stall until one done. LongOpD with RdD=3 while x3 busy -> stall.
- Branch priority: sbStall active and PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
- Forward priority and x0: RdM=RdW=Rs1E=6, both enables set -> 10. Rd=0 everywhere -> 00. FWD_EN=0 instance -> 00 plus stall on RdE match.
- Error and reset: LongDone for non-busy x10 -> SbErr=1, sticky. reset low mid-stall -> busy, cnt and SbErr are 0 immediately.
